// File: rtl/s00_axis_itf_if.sv
// AXI4-Stream slave-side bundle for the s00 receive buffer (no TKEEP/TUSER).
interface s00_axis_itf_if;
  logic        S_AXIS_TVALID;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;

  modport slave  (input S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, output S_AXIS_TREADY);
  modport master (output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, input S_AXIS_TREADY);
endinterface

// File: rtl/s00_axis_itf.sv
// Packet receiver: writes one AXIS packet into a 2^ADDR_W word RAM, truncating
// overlong packets, then hands the buffer to a consumer via a req/ack handshake.
module s00_axis_itf #(
  parameter int ADDR_W = 10
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESETN,
  s00_axis_itf_if.slave     s_axis,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [31:0]       RAM_WDATA,
  output logic              rx_req,
  input  logic              rx_ack,
  output logic [ADDR_W:0]   rx_len,
  output logic              rx_trunc,
  output logic [31:0]       debug_state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    DRAIN    = 3'd2,
    NOTIFY   = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t          r_state;
  logic [ADDR_W:0] r_wcnt;
  logic [15:0]     r_dbg_cnt;
  logic            w_acc;

  // Ready comes straight off the state register, so upstream sees no combinational path.
  assign s_axis.S_AXIS_TREADY = (r_state == RECV) || (r_state == DRAIN);
  assign w_acc = s_axis.S_AXIS_TVALID && s_axis.S_AXIS_TREADY;
  assign debug_state = {1'b0, r_state, 1'b0, rx_trunc, rx_ack, rx_req, 8'h00, r_dbg_cnt};

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_dbg_cnt <= '0;
      RAM_WE    <= 1'b0;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
      rx_req    <= 1'b0;
      rx_len    <= '0;
      rx_trunc  <= 1'b0;
    end else begin
      RAM_WE <= 1'b0;
      if (r_state == IDLE)
        r_dbg_cnt <= '0;
      else if (r_dbg_cnt != 16'hFFFF)
        r_dbg_cnt <= r_dbg_cnt + 16'd1;

      case (r_state)
        IDLE: begin
          r_wcnt   <= '0;
          rx_trunc <= 1'b0;
          r_state  <= RECV;
        end
        RECV: begin
          if (w_acc) begin
            RAM_WE    <= 1'b1;
            RAM_WADDR <= r_wcnt[ADDR_W-1:0];
            RAM_WDATA <= s_axis.S_AXIS_TDATA;
            r_wcnt    <= r_wcnt + ONE;
            if (s_axis.S_AXIS_TLAST) begin
              rx_req  <= 1'b1;
              rx_len  <= r_wcnt + ONE;
              r_state <= NOTIFY;
            end else if (r_wcnt == LAST_SLOT) begin
              rx_trunc <= 1'b1;
              r_state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Overflow beats are swallowed until the packet boundary.
          if (w_acc && s_axis.S_AXIS_TLAST) begin
            rx_req  <= 1'b1;
            rx_len  <= r_wcnt;
            r_state <= NOTIFY;
          end
        end
        NOTIFY: begin
          if (rx_ack) begin
            rx_req  <= 1'b0;
            r_state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!rx_ack) r_state <= IDLE;
        end
        default: begin
          rx_req  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_s00_axis_itf.sv
// Randomized packet bench for s00_axis_itf against a packet-level buffer model.
module tb_s00_axis_itf;
  localparam int AW  = 10;
  localparam int MAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ram_we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          rx_req;
  logic          rx_ack = 1'b0;
  logic [AW:0]   rx_len;
  logic          rx_trunc;
  logic [31:0]   dbg;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [31:0]   sent_q[$];
  bit            req_seen;

  always #5 clk = ~clk;

  s00_axis_itf_if axis();

  s00_axis_itf #(.ADDR_W(AW)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn), .s_axis(axis.slave),
    .RAM_WE(ram_we), .RAM_WADDR(waddr), .RAM_WDATA(wdata),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_len(rx_len), .rx_trunc(rx_trunc),
    .debug_state(dbg)
  );

  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (rx_req) req_seen = 1'b1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_pkt();
    wa_q.delete();
    wd_q.delete();
    sent_q.delete();
    req_seen = 1'b0;
  endtask

  // Offer n beats; record every accepted word in sent_q.
  task automatic drive(input int n, input bit gaps, input bit fixed, input logic [31:0] base,
                       input bit give_last, input bit keep_valid);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 20000) begin
      step();
      cyc++;
      if (!gaps || $urandom_range(1, 0) == 1) begin
        axis.S_AXIS_TVALID = 1'b1;
        axis.S_AXIS_TDATA  = fixed ? base + 32'(sent) : $urandom;
        axis.S_AXIS_TLAST  = give_last && (sent == n - 1);
      end else begin
        axis.S_AXIS_TVALID = 1'b0;
        axis.S_AXIS_TDATA  = $urandom;
        axis.S_AXIS_TLAST  = 1'($urandom_range(1, 0));
      end
      if (axis.S_AXIS_TVALID && axis.S_AXIS_TREADY) begin
        sent_q.push_back(axis.S_AXIS_TDATA);
        sent++;
      end
    end
    chk("drv_done", sent, n);
    step();
    axis.S_AXIS_TVALID = keep_valid;
    axis.S_AXIS_TLAST  = 1'b0;
    axis.S_AXIS_TDATA  = $urandom;
  endtask

  // Consumer handshake plus comparison of the buffer against the accepted beats.
  task automatic finish(input int n, input int hold, input bit early);
    int w = 0;
    int nbad = 0;
    int ws;
    int c = 0;
    int exp_len = (n > MAX) ? MAX : n;
    bit exp_tr  = (n > MAX);
    logic [15:0] d0;
    while (!rx_req && w < 50) begin step(); w++; end
    chk("req_rise", rx_req, 1);
    chk("rx_len", rx_len, exp_len);
    chk("rx_trunc", rx_trunc, exp_tr);
    chk("notify_tready", axis.S_AXIS_TREADY, 0);
    chk("dbg_state_notify", dbg[31:28], 3);
    chk("dbg_flags", dbg[27:24], {1'b0, exp_tr, rx_ack, 1'b1});
    if (early) begin
      step();
      chk("notify_1cyc", rx_req, 0);
    end else begin
      d0 = dbg[15:0];
      ws = wa_q.size();
      repeat (hold) begin
        step();
        if (!rx_req || axis.S_AXIS_TREADY) nbad++;
      end
      if (hold > 0) begin
        chk("hold_bad_cycles", nbad, 0);
        chk("hold_no_we", wa_q.size(), ws);
        chk("dbg_cnt", dbg[15:0], 32'(d0) + hold);
      end
      rx_ack = 1'b1;
      step();
      chk("req_drop", rx_req, 0);
    end
    chk("dbg_state_wrel", dbg[31:28], 4);
    chk("len_hold", rx_len, exp_len);
    chk("trunc_hold", rx_trunc, exp_tr);
    axis.S_AXIS_TVALID = 1'b0;
    rx_ack = 1'b0;
    while (!axis.S_AXIS_TREADY && c < 20) begin step(); c++; end
    chk("tready_ret", c, 2);
    chk("wr_cnt", wa_q.size(), exp_len);
    for (int i = 0; i < exp_len && i < wa_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa_q[i], i);
      chk($sformatf("wr_data[%0d]", i), wd_q[i], sent_q[i]);
    end
  endtask

  task automatic packet(input int n, input bit gaps, input int hold);
    clear_pkt();
    drive(n, gaps, 1'b0, 32'h0, 1'b1, 1'b0);
    finish(n, hold, 1'b0);
  endtask

  initial begin
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TDATA  = '0;
    axis.S_AXIS_TLAST  = 1'b0;
    repeat (3) step();
    chk("rst_tready", axis.S_AXIS_TREADY, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_req", rx_req, 0);
    chk("rst_len", rx_len, 0);
    chk("rst_trunc", rx_trunc, 0);
    chk("rst_dbg", dbg, 0);
    rstn = 1'b1;

    packet(1024, 1'b0, 0);
    clear_pkt();
    drive(5, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b0);
    finish(5, 0, 1'b0);
    chk("a0_first", sent_q.size() > 0 ? sent_q[0] : 0, 32'hA0);
    packet(1030, 1'b0, 0);
    packet(300, 1'b1, 2);

    clear_pkt();
    drive(7, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    finish(7, 100, 1'b0);

    clear_pkt();
    rx_ack = 1'b1;
    drive(4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    finish(4, 0, 1'b1);

    for (int k = 0; k < 6; k++)
      packet($urandom_range(40, 1), 1'($urandom_range(1, 0)), $urandom_range(3, 0));

    clear_pkt();
    drive(10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    rstn = 1'b0;
    step();
    step();
    chk("mid_rst_tready", axis.S_AXIS_TREADY, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_len", rx_len, 0);
    chk("mid_rst_dbg", dbg, 0);
    axis.S_AXIS_TVALID = 1'b0;
    rstn = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_req", req_seen, 0);
    packet(3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/s00_axis_itf.md
S00_AXIS_ITF -- requirements
Module: s00_axis_itf

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, RAM address width; buffer capacity MAX = 2^ADDR_W words.
REQ-002 SHALL have one clock and a synchronous, active-low reset: S_AXIS_ACLK in 1, clock; S_AXIS_ARESETN in 1, synchronous active-low reset.
REQ-003 S_AXIS_TVALID  in  1  upstream data valid.
REQ-004 S_AXIS_TDATA  in  32  stream data.
REQ-005 S_AXIS_TLAST  in  1  last beat of packet.
REQ-006 S_AXIS_TREADY  out  1  block ready to accept a beat.
REQ-007 RAM_WE  out  1  RAM write strobe.
REQ-008 RAM_WADDR  out  ADDR_W  RAM write address.
REQ-009 RAM_WDATA  out  32  RAM write data.
REQ-010 rx_req  out  1  buffer-full request to the consumer.
REQ-011 rx_ack  in  1  consumer acknowledge.
REQ-012 rx_len  out  ADDR_W+1  number of words stored (1..MAX).
REQ-013 rx_trunc  out  1  packet exceeded MAX words and was truncated.
REQ-014 debug_state  out  32  debug status word.

Function
REQ-015 SHALL implement states IDLE(0), RECV(1), DRAIN(2), NOTIFY(3), WAIT_REL(4); any other encoding SHALL return to IDLE next cycle.
REQ-016 S_AXIS_TREADY SHALL be 1 exactly when state is RECV or DRAIN (decoded from the state register, no input-to-output path).
REQ-017 A beat is accepted on a rising edge with TVALID=1 and TREADY=1; TDATA/TLAST SHALL be ignored otherwise.
REQ-018 IDLE: clear word count wcnt (ADDR_W+1 bits) to 0 and rx_trunc to 0; next state RECV unconditionally (one-cycle gap).
REQ-019 RECV accepted beat: RAM_WE=1, RAM_WADDR=wcnt[ADDR_W-1:0], RAM_WDATA=TDATA on the following cycle (1-cycle write latency); wcnt increments by 1.
REQ-020 RAM_WE SHALL be 0 in every cycle not following a RECV accepted beat; RAM_WADDR/RAM_WDATA hold their last values.
REQ-021 RECV accepted beat with TLAST=1: next state NOTIFY (regardless of wcnt).
REQ-022 RECV accepted beat with TLAST=0 and wcnt=MAX-1 (filling last slot): set rx_trunc=1, next state DRAIN.
REQ-023 DRAIN: accept and discard beats (no RAM write, wcnt frozen); accepted beat with TLAST=1 -> NOTIFY.
REQ-024 NOTIFY: rx_req=1, rx_len=wcnt; on rx_ack=1 -> WAIT_REL. rx_ack already 1 on entry SHALL be honoured in the first NOTIFY cycle.
REQ-025 WAIT_REL: rx_req=0; on rx_ack=0 -> IDLE. rx_len and rx_trunc SHALL hold stable from NOTIFY entry until IDLE.
REQ-026 rx_req SHALL be registered and high only while in NOTIFY (rises the cycle NOTIFY is entered).
REQ-027 No beat SHALL be accepted in IDLE, NOTIFY or WAIT_REL; upstream is back-pressured for the full handshake.
REQ-028 A zero-length packet is impossible; rx_len SHALL always be 1..MAX when rx_req=1.
REQ-029 debug_state[31:28]=state code, [27:24]={0,rx_trunc,rx_ack,rx_req}, [23:16]=0, [15:0]=cycles since RECV entry (counter reset to 0 on IDLE, increments in RECV/DRAIN/NOTIFY/WAIT_REL, saturates at 0xFFFF).

Reset
REQ-030 On S_AXIS_ARESETN=0 at a clock edge: state=IDLE, TREADY=0, RAM_WE=0, RAM_WADDR=0, RAM_WDATA=0, rx_req=0, rx_len=0, rx_trunc=0, wcnt=0, debug counter=0.
REQ-031 Reset mid-packet SHALL discard the partial packet; no rx_req for it; first beat after reset release is written to address 0.

Verification
REQ-032 1024-beat packet, TLAST on beat 1024, TVALID continuous -> RAM writes addr 0..1023 with data in order, rx_req=1, rx_len=1024, rx_trunc=0.
REQ-033 5-beat packet 0xA0..0xA4 -> writes addr 0..4, rx_len=5, rx_trunc=0; after ack high/low, TREADY returns 1 two cycles after rx_ack falls.
REQ-034 1030-beat packet -> 1024 writes (addr 0..1023), 6 beats accepted with no RAM_WE, rx_len=1024, rx_trunc=1.
REQ-035 Random TVALID gaps (50%) on 300-beat packet -> no lost/duplicated writes, rx_len=300.
REQ-036 rx_ack held 0 for 100 cycles in NOTIFY while TVALID=1 -> TREADY=0 and rx_req=1 throughout; rx_ack tied 1 -> NOTIFY lasts exactly 1 cycle.
REQ-037 Reset asserted after beat 10 of a packet -> no rx_req; next 3-beat packet writes addr 0..2, rx_len=3.
